// File: rtl/rf_writeback_queue_pkg.sv
// Shared register-file definitions used by the register file, the execute stage
// and the write-back queue.
//   RF_AW / RF_DW : register address and data widths of the 32x32 file
//   RF_ZERO_REG   : hard-wired zero register (%g0); writes to it are discarded
//   wb_entry_t    : one pending write (destination register + value)
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam logic [RF_AW-1:0] RF_ZERO_REG = 5'd0;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_queue_bypass_lookup.sv
// Bypass lookup for one register-file read port. Finds the youngest pending
// write to the requested register among the queued entries.
//   entries_i : queue storage, indexed by pointer
//   valid_i   : per-slot occupancy mask
//   head_i    : pointer to the oldest entry
//   count_i   : number of occupied entries
//   addr_i    : read port address
//   hit_o     : a pending write to addr_i exists (never for register 0)
//   data_o    : value of the youngest matching entry, 0 when no hit
import rf_pkg::*;

module rf_bypass_lookup #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PW-1:0]         head_i,
  input  logic [CW-1:0]         count_i,
  input  logic [RF_AW-1:0]      addr_i,
  output logic                  hit_o,
  output logic [RF_DW-1:0]      data_o
);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one, so
  // the value left behind belongs to the youngest matching entry.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if ((CW'(k) < count_i) && valid_i[idx] &&
          (entries_i[idx].rd == addr_i) && (addr_i != RF_ZERO_REG)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Write-side front end of the 32x32 register file. Buffers execute-stage
// results and drains one per cycle onto the file's single write port; also
// provides a youngest-value bypass for the two read ports.
//   clk, reset              : clock, asynchronous active-high reset
//   wb_valid/wb_rd/wb_data  : result offered by execute; wb_ready = !full
//   rf_hold                 : stall the drain
//   rf_wr_addr/data, rf_ld  : register file write port
//   rd_a_*/rd_b_*           : read port addresses and bypass results
//   count                   : queue occupancy
import rf_pkg::*;

module rf_writeback_queue #(
  parameter  int DEPTH = 4,
  parameter  int AW    = RF_AW,
  parameter  int DW    = RF_DW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          rf_hold,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          rf_ld,
  input  logic [AW-1:0] rd_a_addr,
  output logic          rd_a_hit,
  output logic [DW-1:0] rd_a_data,
  input  logic [AW-1:0] rd_b_addr,
  output logic          rd_b_hit,
  output logic [DW-1:0] rd_b_data,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q;
  wb_entry_t             entry_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         offset;
  logic                  empty;
  logic                  enq;

  assign empty    = (count_q == '0);
  assign wb_ready = (count_q != FULL_CNT);
  assign count    = count_q;

  // A handshake to %g0 completes but leaves nothing behind.
  assign enq = wb_valid && wb_ready && (wb_rd != RF_ZERO_REG);

  assign rf_ld      = !empty && !rf_hold;
  assign rf_wr_addr = empty ? '0 : entries_q[head_q].rd;
  assign rf_wr_data = empty ? '0 : entries_q[head_q].data;

  assign entry_d.rd   = wb_rd;
  assign entry_d.data = wb_data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq)   tail_d = tail_q + PW'(1);
    if (rf_ld) head_d = head_q + PW'(1);
    case ({enq, rf_ld})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is occupied when its distance from head is below the occupancy.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PW'(i) - head_q;
      valid[i] = ({1'b0, offset} < count_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (enq) entries_q[tail_q] <= entry_d;
  end

  rf_bypass_lookup #(.DEPTH(DEPTH)) u_bypass_a (
    .entries_i (entries_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .count_i   (count_q),
    .addr_i    (rd_a_addr),
    .hit_o     (rd_a_hit),
    .data_o    (rd_a_data)
  );

  rf_bypass_lookup #(.DEPTH(DEPTH)) u_bypass_b (
    .entries_i (entries_q),
    .valid_i   (valid),
    .head_i    (head_q),
    .count_i   (count_q),
    .addr_i    (rd_b_addr),
    .hit_o     (rd_b_hit),
    .data_o    (rd_b_data)
  );

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        rf_hold;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_ld;
  logic [4:0]  rd_a_addr;
  logic        rd_a_hit;
  logic [31:0] rd_a_data;
  logic [4:0]  rd_b_addr;
  logic        rd_b_hit;
  logic [31:0] rd_b_data;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  ent_t        q[$];
  logic [31:0] file_ref [32];
  logic [31:0] file_dut [32];

  always #5 clk = ~clk;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .rf_hold    (rf_hold),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_ld      (rf_ld),
    .rd_a_addr  (rd_a_addr),
    .rd_a_hit   (rd_a_hit),
    .rd_a_data  (rd_a_data),
    .rd_b_addr  (rd_b_addr),
    .rd_b_hit   (rd_b_hit),
    .rd_b_data  (rd_b_data),
    .count      (count)
  );

  // Stand-in for the register file: latches the write port on the edge.
  always @(posedge clk) begin
    if (rf_ld) file_dut[rf_wr_addr] <= rf_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Youngest queued value for an address, searched newest-first.
  task automatic model_lookup(input logic [4:0] addr, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (addr != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].rd == addr) begin
          hit  = 1'b1;
          data = q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic        h;
    logic [31:0] d;
    chk("ready", wb_ready, q.size() < DEPTH);
    chk("count", count, q.size());
    chk("ld", rf_ld, (q.size() != 0) && !rf_hold);
    chk("waddr", rf_wr_addr, (q.size() != 0) ? q[0].rd : 5'd0);
    chk("wdata", rf_wr_data, (q.size() != 0) ? q[0].data : 32'd0);
    model_lookup(rd_a_addr, h, d);
    chk("a_hit", rd_a_hit, h);
    chk("a_data", rd_a_data, d);
    model_lookup(rd_b_addr, h, d);
    chk("b_hit", rd_b_hit, h);
    chk("b_data", rd_b_data, d);
  endtask

  task automatic check_file();
    for (int r = 0; r < 32; r++) chk($sformatf("file_r%0d", r), file_dut[r], file_ref[r]);
  endtask

  // One clock: check against the model mid-cycle, then advance the model
  // with the values present at the edge. Returns 1 time unit after the edge.
  task automatic step();
    bit   exp_ld;
    bit   exp_acc;
    ent_t e;
    @(negedge clk);
    check_outputs();
    exp_ld  = (q.size() != 0) && !rf_hold;
    exp_acc = wb_valid && (q.size() < DEPTH) && (wb_rd != 5'd0);
    e.rd    = wb_rd;
    e.data  = wb_data;
    @(posedge clk);
    if (exp_ld) begin
      file_ref[q[0].rd] = q[0].data;
      void'(q.pop_front());
    end
    if (exp_acc) q.push_back(e);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      file_ref[r] = '0;
      file_dut[r] = '0;
    end
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    rf_hold = 1'b0; rd_a_addr = '0; rd_b_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_ld", rf_ld, 0);
    chk("rst_waddr", rf_wr_addr, 0);
    chk("rst_wdata", rf_wr_data, 0);
    chk("rst_ahit", rd_a_hit, 0);
    chk("rst_bdata", rd_b_data, 0);

    // Single write, minimum latency.
    push(5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_ld", rf_ld, 1);
    chk("t1_addr", rf_wr_addr, 5);
    chk("t1_data", rf_wr_data, 32'hDEADBEEF);
    step();
    chk("t1_r5", file_dut[5], 32'hDEADBEEF);
    chk("t1_cnt", count, 0);

    // Fill under hold, refuse a fifth, drain in order.
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
    chk("full_cnt", count, 4);
    chk("full_rdy", wb_ready, 0);
    push(5'd9, 32'h99);
    chk("full_refuse", count, 4);
    rf_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_ld", rf_ld, 1);
      chk("drain_addr", rf_wr_addr, i);
      chk("drain_data", rf_wr_data, i * 'h11);
      step();
    end
    chk("drain_empty", count, 0);
    check_file();

    // Youngest-value bypass.
    rf_hold = 1'b1;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    rd_a_addr = 5'd7;
    rd_b_addr = 5'd8;
    #1;
    chk("byp_ahit", rd_a_hit, 1);
    chk("byp_adata", rd_a_data, 32'hB);
    chk("byp_bhit", rd_b_hit, 0);
    chk("byp_bdata", rd_b_data, 0);
    rf_hold = 1'b0;
    step();
    step();

    // Writes to register 0 are dropped.
    rd_a_addr = 5'd0;
    push(5'd0, 32'hFFFF_FFFF);
    #1;
    chk("g0_cnt", count, 0);
    chk("g0_ld", rf_ld, 0);
    chk("g0_hit", rd_a_hit, 0);
    step();

    // Steady state at count 3 with accept and drain every cycle, wrapping pointers.
    rf_hold = 1'b1;
    for (int n = 0; n < 3; n++) push(5'(10 + n % 5), 32'h100 + 32'(n));
    rf_hold = 1'b0;
    for (int n = 3; n < 13; n++) begin
      wb_valid = 1'b1;
      wb_rd    = 5'(10 + n % 5);
      wb_data  = 32'h100 + 32'(n);
      #1;
      chk("wrap_cnt", count, 3);
      chk("wrap_data", rf_wr_data, 32'h100 + 32'(n - 3));
      step();
    end
    wb_valid = 1'b0;
    repeat (3) step();
    check_file();

    // Asynchronous reset between edges discards pending writes.
    rf_hold = 1'b1;
    push(5'd20, 32'hC0DE0020);
    push(5'd21, 32'hC0DE0021);
    push(5'd22, 32'hC0DE0022);
    rf_hold   = 1'b0;
    rd_a_addr = 5'd20;
    #1;
    chk("prerst_ld", rf_ld, 1);
    reset = 1'b1;
    #1;
    chk("arst_ld", rf_ld, 0);
    chk("arst_cnt", count, 0);
    chk("arst_hit", rd_a_hit, 0);
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) step();
    chk("arst_r20", file_dut[20], 0);
    check_file();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      wb_valid  = ($urandom_range(0, 2) != 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      rf_hold   = ($urandom_range(0, 3) == 0);
      rd_a_addr = 5'($urandom_range(0, 7));
      rd_b_addr = 5'($urandom_range(0, 7));
      step();
    end
    wb_valid = 1'b0;
    rf_hold  = 1'b0;
    repeat (DEPTH + 1) step();
    check_file();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
